// File: rtl/systola_pkg.sv
// systola_pkg: shared types, limits and sizing helper for the systolic array buffers
package systola_pkg;
  localparam int DWIDTH_DEF = 8;
  typedef logic [DWIDTH_DEF-1:0] data_t;
  localparam int MAX_PADDING = 15;
  function automatic int clog2_depth(input int depth);
    int n = 0;
    while ((1 << n) < depth) n++;
    return n;
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: PADDING-stage strobe delay line; PADDING=0 is a wire-through
module skew_line import systola_pkg::*; #(
  parameter int PADDING = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  if (PADDING > MAX_PADDING) begin : g_bad
    $error("skew_line: PADDING exceeds MAX_PADDING");
  end
  if (PADDING == 0) begin : g_wire
    logic unused;
    assign unused = &{1'b0, clk, rstn};
    assign q_o = d_i;
  end else begin : g_sr
    logic [PADDING-1:0] sr_q, sr_d;
    assign sr_d = (sr_q << 1) | PADDING'(d_i);
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sr_q <= '0;
      else sr_q <= sr_d;
    end
    assign q_o = sr_q[PADDING-1];
  end
endmodule

// File: rtl/outbuf.sv
// outbuf: per-column output deskew plus show-ahead FIFO.
// Define OUTBUF_ERR_EN to add sticky ovf/unf error ports.
module outbuf import systola_pkg::*; #(
  parameter int PADDING = 0,
  parameter int DEPTH   = 8,
  parameter int DWIDTH  = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              write,
  input  logic [DWIDTH-1:0] din,
  input  logic              read,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
`ifdef OUTBUF_ERR_EN
  output logic              ovf,
  output logic              unf,
`endif
  output logic              full
);
  localparam int AW = clog2_depth(DEPTH);
  localparam int CW = AW + 1;
  logic cap, do_push, do_pop, empty_q, full_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] mem [DEPTH];
  skew_line #(.PADDING(PADDING)) u_skew (
    .clk (clk),
    .rstn(rstn),
    .d_i (write),
    .q_o (cap)
  );
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign do_pop  = read && !empty_q;
  assign do_push = cap && (!full_q || do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      empty_q <= cnt_d == '0;
      full_q  <= cnt_d == CW'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end
  assign dout  = empty_q ? '0 : mem[rptr_q];
  assign empty = empty_q;
  assign full  = full_q;
`ifdef OUTBUF_ERR_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (cap && !do_push) ovf_q <= 1'b1;
      if (read && empty_q) unf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
  assign unf = unf_q;
`endif
endmodule
